// File: rtl/seed_lfsr_noise_gen.sv
// Seed-driven Galois LFSR noise source.
// Debounces the software seed register, stages each new value, reloads the
// LFSR on the next pipeline sync and emits OUT_BITS noise bits per enabled
// cycle, with sync_out aligned to the first sample of a reseeded sequence.
module seed_lfsr_noise_gen #(
  parameter int unsigned             LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0]   TAPS          = 32'h80200003,
  parameter int unsigned             OUT_BITS      = 8,
  parameter int unsigned             STABLE_CYCLES = 4
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [LFSR_WIDTH-1:0] seed_data,
  input  logic                  sync_in,
  input  logic                  en,
  output logic [OUT_BITS-1:0]   noise_out,
  output logic                  noise_valid,
  output logic                  sync_out,
  output logic                  seed_pending,
  output logic [15:0]           seed_loads
);

  // One extra bit so the counter cannot wrap back to the capture value.
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;

  typedef enum logic {IDLE, RUN} mode_t;

  mode_t                 r_mode;
  mode_t                 w_mode_nxt;
  logic [LFSR_WIDTH-1:0] r_seed_q;
  logic [CNT_W-1:0]      r_stab_cnt;
  logic                  r_captured;
  logic [LFSR_WIDTH-1:0] r_staged;
  logic                  r_pending;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [OUT_BITS-1:0]   r_noise;
  logic                  r_valid;
  logic [15:0]           r_loads;
  logic                  r_sync_d1;
  logic                  r_sync_d2;

  logic                  w_seed_eq;
  logic                  w_capture;
  logic                  w_load;
  logic                  w_advance;
  logic [LFSR_WIDTH-1:0] w_load_val;
  logic [LFSR_WIDTH-1:0] w_lfsr_step;

  // Unrolled OUT_BITS-step Galois advance, single combinational stage.
  function automatic logic [LFSR_WIDTH-1:0] f_step(input logic [LFSR_WIDTH-1:0] s);
    logic [LFSR_WIDTH-1:0] v;
    v = s;
    for (int unsigned i = 0; i < OUT_BITS; i++) begin
      v = (v >> 1) ^ (v[0] ? TAPS : '0);
    end
    return v;
  endfunction

  assign w_seed_eq   = (seed_data == r_seed_q);
  assign w_capture   = w_seed_eq && !r_captured &&
                       (r_stab_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign w_load      = sync_in && r_pending;
  assign w_load_val  = (r_staged == '0) ? LFSR_WIDTH'(1) : r_staged;
  assign w_lfsr_step = f_step(r_lfsr);

  // Mode register.
  always_ff @(posedge user_clk) begin
    if (user_rst) r_mode <= IDLE;
    else          r_mode <= w_mode_nxt;
  end

  // Next mode and advance qualifier; a load always wins over an advance.
  always_comb begin
    w_mode_nxt = r_mode;
    w_advance  = 1'b0;
    if (w_load) begin
      w_mode_nxt = RUN;
    end else if (r_mode == RUN && en) begin
      w_advance = 1'b1;
    end
  end

  // Seed debounce: count consecutive equal samples, capture each value once.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_seed_q   <= '0;
      r_stab_cnt <= '0;
      r_captured <= 1'b0;
    end else begin
      r_seed_q <= seed_data;
      if (!w_seed_eq) begin
        r_stab_cnt <= '0;
        r_captured <= 1'b0;
      end else if (!r_captured) begin
        r_stab_cnt <= r_stab_cnt + CNT_W'(1);
      end
      if (w_capture) r_captured <= 1'b1;
    end
  end

  // Staging: a capture coinciding with a load keeps the new seed pending,
  // while the load itself consumes the previously staged value.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_staged  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_capture) begin
        r_staged  <= seed_data;
        r_pending <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
    end
  end

  // LFSR state, noise sample and reload counter.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_lfsr  <= '0;
      r_noise <= '0;
      r_valid <= 1'b0;
      r_loads <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_load) begin
        r_lfsr  <= w_load_val;
        r_loads <= r_loads + 16'd1;
      end else if (w_advance) begin
        r_noise <= r_lfsr[OUT_BITS-1:0];
        r_valid <= 1'b1;
        r_lfsr  <= w_lfsr_step;
      end
    end
  end

  // Two-stage sync delay, lining up with the first post-reload sample.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_sync_d1 <= 1'b0;
      r_sync_d2 <= 1'b0;
    end else begin
      r_sync_d1 <= sync_in;
      r_sync_d2 <= r_sync_d1;
    end
  end

  assign noise_out    = r_noise;
  assign noise_valid  = r_valid;
  assign sync_out     = r_sync_d2;
  assign seed_pending = r_pending;
  assign seed_loads   = r_loads;

endmodule

// File: doc/seed_lfsr_noise_gen.md
Name: seed_lfsr_noise_gen

Overview:
Downstream consumer of the 32-bit seed_data software register in the user_clk domain of the F-engine. Debounces and stages each new seed written by the PPC. Reloads a Galois LFSR with that seed on the next pipeline sync pulse. Emits an OUT_BITS-wide pseudo-random noise stream, with a sync marker aligned to the first sample of each reseeded sequence, for test-vector and dither injection.

Parameters:
LFSR_WIDTH, 32, LFSR state width; equals the seed register width.
TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1).
OUT_BITS, 8, noise bits emitted per cycle; also the number of LFSR steps per enabled cycle (1..LFSR_WIDTH).
STABLE_CYCLES, 4, consecutive equal cycles required before a seed value is accepted (>=2).

Ports:
user_clk  in  1  sole clock.
user_rst  in  1  synchronous, active-high reset.
seed_data  in  LFSR_WIDTH  seed from the software register; quasi-static, already in the user_clk domain.
sync_in  in  1  single-cycle pipeline sync pulse.
en  in  1  advance enable; when high, the LFSR steps OUT_BITS times.
noise_out  out  OUT_BITS  registered noise sample.
noise_valid  out  1  noise_out is valid this cycle.
sync_out  out  1  sync_in delayed 2 cycles; marks the first sample after a reload.
seed_pending  out  1  a staged seed is waiting for sync.
seed_loads  out  16  count of reloads performed; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (user_rst=1 at a clock edge):
  - noise_out=0, noise_valid=0, sync_out=0, seed_pending=0, seed_loads=0.
  - lfsr=0, seed_q=0, staged=0, stab_cnt=0, captured=0.
  - Mode returns to IDLE.
  - A reset mid-sequence discards any pending seed.
- Seed debounce:
  - Each cycle seed_q<=seed_data.
  - If seed_data!=seed_q: stab_cnt<=0, captured<=0.
  - Else, if !captured: stab_cnt increments.
  - When stab_cnt==STABLE_CYCLES-1 and seed_data==seed_q: staged<=seed_data, seed_pending<=1, captured<=1.
  - A value is captured once; a rewrite of the same value is not re-captured.
  - The first stable value after reset, including 0, is captured.
  - Capture while already pending overwrites staged; seed_pending stays 1.
- Modes:
  - IDLE: no seed loaded yet. lfsr held, noise_valid=0.
  - RUN: normal operation.
- Load:
  - Condition: sync_in=1 with seed_pending=1, in any mode.
  - Next cycle: lfsr<=(staged==0 ? 1 : staged) (lock-up avoidance), seed_loads++, mode<=RUN.
  - seed_pending<=0, unless a capture occurs in the same cycle. In that case the load uses the old staged, staged takes the new value, and seed_pending stays 1 for the next sync.
  - Load ignores en.
  - sync_in without pending: no load; sync_out still pulses.
- Advance:
  - In RUN with en=1 and no load this cycle: noise_out<=lfsr[OUT_BITS-1:0] (pre-advance state), noise_valid<=1.
  - Then lfsr<=OUT_BITS iterations of s=(s>>1)^(s[0]?TAPS:0).
  - en=0: lfsr holds, noise_valid<=0, noise_out holds.
  - In a load cycle, noise_valid<=0.
- Latency:
  - sync_in at cycle T with pending: lfsr=seed at T+1.
  - With en=1 at T+1: noise_out=seed[OUT_BITS-1:0], noise_valid=1, sync_out=1 at T+2.
- The unrolled step is purely combinational within a single register stage; no extra pipeline depth.

Test Plan:
1. Reset; seed_data=1 held 6 cycles -> seed_pending=1 at the STABLE_CYCLES-th cycle after the value appears; noise_valid=0 throughout; seed_loads=0.
2. Pulse sync_in with en=1 -> 2 cycles later sync_out=1 and noise_out=8'h01; next noise_out=8'h02 (lfsr=32'hDB36C002); seed_loads=1; seed_pending=0.
3. seed_data toggles 5->6->5 each cycle for 10 cycles, then holds 5 -> no capture while toggling; capture exactly STABLE_CYCLES cycles after settling.
4. seed_data=0 stable, then sync -> sequence identical to seed 1 (8'h01, 8'h02).
5. Capture of a new seed in the same cycle as sync_in with an old seed pending -> the old seed is loaded, seed_pending stays 1, the next sync loads the new seed, and seed_loads increments twice.
6. en low for 3 cycles mid-stream -> noise_valid=0 for those cycles; the sequence resumes without skipped samples. Assert user_rst mid-stream -> all outputs 0 and IDLE until the next seed plus sync.
